// File: rtl/ysyx_25030081_pkg.sv
// Shared definitions for the load/store path: access size codes, LSU state encoding
// and the alignment legality helper.
package ysyx_25030081_pkg;

   localparam logic [1:0] MEM_OP_B = 2'b00;
   localparam logic [1:0] MEM_OP_H = 2'b01;
   localparam logic [1:0] MEM_OP_W = 2'b10;
   localparam int         MEM_OP_UNSIGNED = 2;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_REQ  = 2'b01,
      LSU_WAIT = 2'b10,
      LSU_RESP = 2'b11
   } lsu_state_e;

   // High when the size code is illegal or the byte offset breaks natural alignment.
   function automatic logic mem_op_bad(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         MEM_OP_B: bad = 1'b0;
         MEM_OP_H: bad = off[0];
         MEM_OP_W: bad = (off != 2'b00);
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ysyx_25030081_lsu_fmt.sv
// Combinational data formatting: store lane alignment (data and byte enables) and
// load lane extraction with sign/zero extension.
module ysyx_25030081_lsu_fmt
   import ysyx_25030081_pkg::*;
(
   input  logic [1:0]  st_size_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_wdata_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_wmask_o,
   input  logic [1:0]  ld_size_i,
   input  logic        ld_uns_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_word_i,
   output logic [31:0] ld_data_o
);

   logic [3:0]  base_mask_s;
   logic [31:0] ld_shift_s;

   // Store alignment and load extraction, both keyed on the byte offset within the word.
   always_comb begin
      base_mask_s = 4'b0000;
      ld_data_o   = 32'h0000_0000;
      case (st_size_i)
         MEM_OP_B: base_mask_s = 4'b0001;
         MEM_OP_H: base_mask_s = 4'b0011;
         MEM_OP_W: base_mask_s = 4'b1111;
         default:  base_mask_s = 4'b0000;
      endcase
      st_wmask_o = base_mask_s << st_off_i;
      st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
      ld_shift_s = ld_word_i >> {ld_off_i, 3'b000};
      case (ld_size_i)
         MEM_OP_B: begin
            if (ld_uns_i) ld_data_o = {24'h00_0000, ld_shift_s[7:0]};
            else          ld_data_o = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
         end
         MEM_OP_H: begin
            if (ld_uns_i) ld_data_o = {16'h0000, ld_shift_s[15:0]};
            else          ld_data_o = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
         end
         MEM_OP_W: ld_data_o = ld_shift_s;
         default:  ld_data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: accepts one EXU access, issues a word-aligned memory request,
// waits for the response (bounded by TIMEOUT) and returns formatted load data to WBU.
module ysyx_25030081_lsu
   import ysyx_25030081_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_ren,
   input  logic                  in_wen,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   input  logic [2:0]            in_mem_op,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_rdata,
   output logic                  out_err
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e            state_q;
   logic                  mem_wen_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [3:0]            mem_wmask_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [1:0]            off_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] out_rdata_q;
   logic                  out_err_q;

   logic                  accept_s;
   logic                  bad_s;
   logic [31:0]           st_wdata_s;
   logic [3:0]            st_wmask_s;
   logic [31:0]           ld_data_s;
   logic [DATA_WIDTH-1:0] rsp_result_s;

   ysyx_25030081_lsu_fmt u_fmt (
      .st_size_i  (in_mem_op[1:0]),
      .st_off_i   (in_addr[1:0]),
      .st_wdata_i (in_wdata),
      .st_wdata_o (st_wdata_s),
      .st_wmask_o (st_wmask_s),
      .ld_size_i  (size_q),
      .ld_uns_i   (uns_q),
      .ld_off_i   (off_q),
      .ld_word_i  (mem_rsp_rdata),
      .ld_data_o  (ld_data_s)
   );

   assign accept_s     = in_valid & (in_ren | in_wen);
   assign bad_s        = mem_op_bad(in_mem_op[1:0], in_addr[1:0]) | (in_ren & in_wen);
   assign rsp_result_s = mem_wen_q ? {DATA_WIDTH{1'b0}} : ld_data_s;

   assign in_ready      = (state_q == LSU_IDLE);
   assign mem_req_valid = (state_q == LSU_REQ);
   assign out_valid     = (state_q == LSU_RESP);
   assign mem_wen       = mem_wen_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = mem_wmask_q;
   assign out_rdata     = out_rdata_q;
   assign out_err       = out_err_q;

   // Access sequencer with all request/response fields held in registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LSU_IDLE;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= {ADDR_WIDTH{1'b0}};
         mem_wdata_q <= {DATA_WIDTH{1'b0}};
         mem_wmask_q <= 4'b0000;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         cnt_q       <= {CNT_W{1'b0}};
         out_rdata_q <= {DATA_WIDTH{1'b0}};
         out_err_q   <= 1'b0;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (accept_s) begin
                  mem_wen_q   <= in_wen & ~in_ren;
                  mem_addr_q  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata_q <= st_wdata_s;
                  mem_wmask_q <= st_wmask_s;
                  size_q      <= in_mem_op[1:0];
                  uns_q       <= in_mem_op[MEM_OP_UNSIGNED];
                  off_q       <= in_addr[1:0];
                  out_rdata_q <= {DATA_WIDTH{1'b0}};
                  out_err_q   <= bad_s;
                  state_q     <= bad_s ? LSU_RESP : LSU_REQ;
               end
            end
            LSU_REQ: begin
               if (mem_req_ready) begin
                  if (mem_rsp_valid) begin
                     out_rdata_q <= rsp_result_s;
                     out_err_q   <= 1'b0;
                     state_q     <= LSU_RESP;
                  end else begin
                     cnt_q   <= {CNT_W{1'b0}};
                     state_q <= LSU_WAIT;
                  end
               end
            end
            LSU_WAIT: begin
               if (mem_rsp_valid) begin
                  out_rdata_q <= rsp_result_s;
                  out_err_q   <= 1'b0;
                  state_q     <= LSU_RESP;
               end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                  out_rdata_q <= {DATA_WIDTH{1'b0}};
                  out_err_q   <= 1'b1;
                  state_q     <= LSU_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            LSU_RESP: begin
               if (out_ready) state_q <= LSU_IDLE;
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

endmodule
